hazard_mdu_ctrl: RTL and testbench
==================================

Name: hazard_mdu_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Computes the stall, the ID/EX flush and the forwarding-mux selects from the Tuse/Tnew scheme. The Tnew values are the ones carried and decremented (saturating at 0) through the pipeline registers.
- Sequences the multi-cycle mult/div unit with a busy countdown FSM.
- Keeps a free-running stall-cycle counter for performance debug.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rs_D  in  5  ID-stage source register rs
- rt_D  in  5  ID-stage source register rt
- Tuse_rs_D  in  2  cycles until rs is consumed; 3 = not used
- Tuse_rt_D  in  2  cycles until rt is consumed; 3 = not used
- md_use_D  in  1  ID instruction touches HI/LO or the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- rs_E  in  5  EX-stage rs
- rt_E  in  5  EX-stage rt
- WA_E  in  5  EX-stage destination register
- GRFWE_E  in  1  EX-stage register-file write enable
- Tnew_E  in  2  EX-stage Tnew
- md_start_E  in  1  EX-stage mult/div start (one-cycle pulse, valid while not stalled)
- md_div_E  in  1  1 = div type, 0 = mult type
- rt_M  in  5  MEM-stage rt (store data)
- WA_M  in  5  MEM-stage destination register
- GRFWE_M  in  1  MEM-stage write enable
- Tnew_M  in  2  MEM-stage Tnew
- WA_W  in  5  WB-stage destination register
- GRFWE_W  in  1  WB-stage write enable
- stall  out  1  freeze PC and IF/ID; flush ID/EX
- fwd_rs_D  out  2  ID-stage rs mux select
- fwd_rt_D  out  2  ID-stage rt mux select
- fwd_rs_E  out  2  EX-stage rs mux select
- fwd_rt_E  out  2  EX-stage rt mux select
- fwd_rt_M  out  1  MEM-stage store data: 1 = WB value
- md_busy  out  1  MDU result not yet ready
- stall_cnt  out  32  total cycles with stall=1

Behaviour:
- Forward select encoding: 0 = register file / pipeline value, 1 = MEM-stage result, 2 = WB-stage result, 3 = reserved (never driven).
- Match rule, stage X against register r: r != 0, GRFWE_X = 1, WA_X = r.
- Data stall, rs (rt identical): asserted when either condition holds.
  - Match at E and Tuse_rs_D < Tnew_E.
  - Match at M and Tuse_rs_D < Tnew_M.
- WB never causes a stall; the register file writes first-half or bypasses.
- MDU stall: md_use_D = 1 and (md_busy = 1 or md_start_E = 1).
- stall = data stall OR MDU stall. Combinational; no registered latency.
- fwd_*_D:
  - 1 if M matches and Tnew_M = 0.
  - Else 2 if W matches.
  - Else 0.
  - A match at E is never forwarded to D; the stall covers it.
- fwd_*_E: same rule using rs_E/rt_E.
- fwd_rt_M: 1 if W matches rt_M, else 0.
- MDU FSM, states IDLE and BUSY, 4-bit counter cnt:
  - IDLE, md_start_E = 1: cnt <= (md_div_E ? DIV_CYCLES : MULT_CYCLES); go to BUSY.
  - BUSY: cnt decrements every cycle. When cnt = 1, the next state is IDLE with cnt = 0.
  - md_start_E while BUSY is a protocol violation (prevented by the stall). The FSM ignores it and keeps its count.
  - md_busy = 1 exactly while in BUSY, i.e. for N cycles after the start edge.
- stall_cnt increments by 1 on each rising clk with stall = 1. It wraps from 0xFFFFFFFF to 0.
- Reset (asynchronous, takes effect mid-operation too): FSM -> IDLE, cnt = 0, md_busy = 0, stall_cnt = 0.
- Combinational outputs follow their inputs during reset; with all-zero pipeline inputs they evaluate to 0.
- Simultaneous events:
  - Data stall and MDU stall together: stall = 1, counted once.
  - If both M and W match, M has priority.

Test Plan:
- lw $1 at E (WA_E=1, GRFWE_E=1, Tnew_E=2); D has rs_D=1, Tuse_rs_D=0 -> stall=1. Next cycle, lw at M (Tnew_M=1) -> stall=1. Next cycle, lw at W -> stall=0 and fwd_rs_D=2.
- addu $3 at M (Tnew_M=0, WA_M=3) and older addu $3 at W; rs_E=3 -> fwd_rs_E=1. Set rs_E=0 (with WA_M=WA_W=0) -> fwd_rs_E=0 and stall=0.
- Pulse md_start_E=1 with md_div_E=1 -> md_busy high for exactly 10 cycles. With md_use_D=1 throughout -> stall=1 during the start cycle plus those 10 cycles. Mult variant -> busy for 5 cycles.
- Hold data-stall conditions for 7 cycles -> stall_cnt = 7. Preload near wrap via long run, or force stall_cnt = 0xFFFFFFFF in the sim, then 1 stall cycle -> stall_cnt = 0.
- Assert reset asynchronously between clock edges, 3 cycles into a div -> md_busy = 0 immediately, stall_cnt = 0. After release, a new mult runs the full 5 cycles.
- Store at M with rt_M=4 while W writes $4 -> fwd_rt_M=1. Same scenario with GRFWE_W=0 -> fwd_rt_M=0.

Source files
------------

// File: rtl/hazard_mdu_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew stall, forwarding selects,
// mult/div busy sequencing and a stall-cycle performance counter.

module hazard_fwd_sel (
  input  logic [4:0] r,
  input  logic [4:0] wa_m,
  input  logic       we_m,
  input  logic [1:0] tnew_m,
  input  logic [4:0] wa_w,
  input  logic       we_w,
  output logic [1:0] sel
);
  logic hit_m, hit_w;

  assign hit_m = (r != 5'd0) && we_m && (wa_m == r);
  assign hit_w = (r != 5'd0) && we_w && (wa_w == r);

  // A MEM producer is only usable once its result exists (Tnew = 0); otherwise the stall holds D.
  always_comb begin
    sel = 2'd0;
    if (hit_m && tnew_m == 2'd0) sel = 2'd1;
    else if (hit_w)              sel = 2'd2;
  end
endmodule

module hazard_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic        md_use_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  WA_E,
  input  logic        GRFWE_E,
  input  logic [1:0]  Tnew_E,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic [4:0]  rt_M,
  input  logic [4:0]  WA_M,
  input  logic        GRFWE_M,
  input  logic [1:0]  Tnew_M,
  input  logic [4:0]  WA_W,
  input  logic        GRFWE_W,
  output logic        stall,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        fwd_rt_M,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);
  localparam int NUM_SRC = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [NUM_SRC-1:0][4:0] src;
  logic [NUM_SRC-1:0][1:0] sel;
  logic [1:0][4:0]         src_d;
  logic [1:0][1:0]         tuse_d;
  logic [1:0]              stall_src;
  logic                    data_stall, md_stall;
  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;

  assign src = {rt_E, rs_E, rt_D, rs_D};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    hazard_fwd_sel u_sel (
      .r(src[i]), .wa_m(WA_M), .we_m(GRFWE_M), .tnew_m(Tnew_M),
      .wa_w(WA_W), .we_w(GRFWE_W), .sel(sel[i])
    );
  end

  assign fwd_rs_D = sel[0];
  assign fwd_rt_D = sel[1];
  assign fwd_rs_E = sel[2];
  assign fwd_rt_E = sel[3];
  assign fwd_rt_M = (rt_M != 5'd0) && GRFWE_W && (WA_W == rt_M);

  assign src_d  = {rt_D, rs_D};
  assign tuse_d = {Tuse_rt_D, Tuse_rs_D};

  // Tuse = 3 marks an unused operand and can never be below a 2-bit Tnew.
  for (genvar i = 0; i < 2; i++) begin : g_stall
    assign stall_src[i] =
      ((src_d[i] != 5'd0) && GRFWE_E && (WA_E == src_d[i]) && (tuse_d[i] < Tnew_E)) ||
      ((src_d[i] != 5'd0) && GRFWE_M && (WA_M == src_d[i]) && (tuse_d[i] < Tnew_M));
  end

  assign data_stall = |stall_src;
  assign md_stall   = md_use_D && (md_busy || md_start_E);
  assign stall      = data_stall || md_stall;
  assign md_busy    = (state == BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A start seen while BUSY is ignored; the stall keeps it from happening legally.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (md_start_E) begin
        cnt_n   = md_div_E ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        state_n = BUSY;
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          cnt_n   = 4'd0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        cnt_n   = 4'd0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      stall_cnt <= 32'd0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
  end
endmodule

// File: tb/tb_hazard_mdu_ctrl.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_hazard_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, rs_E, rt_E, WA_E, rt_M, WA_M, WA_W;
  logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic        md_use_D, GRFWE_E, md_start_E, md_div_E, GRFWE_M, GRFWE_W;
  logic        stall, fwd_rt_M, md_busy;
  logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [31:0] stall_cnt;

  hazard_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .md_use_D(md_use_D), .rs_E(rs_E), .rt_E(rt_E), .WA_E(WA_E),
    .GRFWE_E(GRFWE_E), .Tnew_E(Tnew_E), .md_start_E(md_start_E),
    .md_div_E(md_div_E), .rt_M(rt_M), .WA_M(WA_M), .GRFWE_M(GRFWE_M),
    .Tnew_M(Tnew_M), .WA_W(WA_W), .GRFWE_W(GRFWE_W),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {S_STALL, S_FRSD, S_FRTD, S_FRSE, S_FRTE, S_FRTM, S_BUSY, S_CNT} sig_t;
  typedef struct {
    string       name;
    sig_t        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [31:0] dut_val(sig_t s);
    case (s)
      S_STALL: return {31'd0, stall};
      S_FRSD:  return {30'd0, fwd_rs_D};
      S_FRTD:  return {30'd0, fwd_rt_D};
      S_FRSE:  return {30'd0, fwd_rs_E};
      S_FRTE:  return {30'd0, fwd_rt_E};
      S_FRTM:  return {31'd0, fwd_rt_M};
      S_BUSY:  return {31'd0, md_busy};
      default: return stall_cnt;
    endcase
  endfunction

  // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = dut_val(e.sig);
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input string name, input sig_t s, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sig = s; e.exp = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; Tuse_rs_D = 3; Tuse_rt_D = 3; md_use_D = 0;
    rs_E = 0; rt_E = 0; WA_E = 0; GRFWE_E = 0; Tnew_E = 0;
    md_start_E = 0; md_div_E = 0;
    rt_M = 0; WA_M = 0; GRFWE_M = 0; Tnew_M = 0;
    WA_W = 0; GRFWE_W = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    #1;
    expect_v("rst_stall", S_STALL, 0);
    expect_v("rst_fwd_rs_D", S_FRSD, 0);
    expect_v("rst_fwd_rt_E", S_FRTE, 0);
    expect_v("rst_fwd_rt_M", S_FRTM, 0);
    expect_v("rst_busy", S_BUSY, 0);
    expect_v("rst_cnt", S_CNT, 0);
    step();
    reset = 1'b0;

    // lw $1 walking E -> M -> W against a D consumer with Tuse=0
    step();
    WA_E = 1; GRFWE_E = 1; Tnew_E = 2; rs_D = 1; Tuse_rs_D = 0;
    expect_v("lw_E_stall", S_STALL, 1);
    expect_v("lw_E_fwd", S_FRSD, 0);
    step();
    WA_E = 0; GRFWE_E = 0; Tnew_E = 0; WA_M = 1; GRFWE_M = 1; Tnew_M = 1;
    expect_v("lw_M_stall", S_STALL, 1);
    expect_v("lw_M_fwd", S_FRSD, 0);
    step();
    WA_M = 0; GRFWE_M = 0; Tnew_M = 0; WA_W = 1; GRFWE_W = 1;
    expect_v("lw_W_stall", S_STALL, 0);
    expect_v("lw_W_fwd", S_FRSD, 2);
    expect_v("lw_cnt", S_CNT, 2);

    // addu $3 at M and W: M wins
    step();
    clear_inputs();
    WA_M = 3; GRFWE_M = 1; Tnew_M = 0; WA_W = 3; GRFWE_W = 1;
    rs_E = 3; rt_D = 3; Tuse_rt_D = 1;
    expect_v("addu_fwd_rs_E", S_FRSE, 1);
    expect_v("addu_fwd_rt_D", S_FRTD, 1);
    expect_v("addu_stall", S_STALL, 0);
    step();
    GRFWE_M = 0; rs_E = 0; rt_E = 3; rt_D = 0; Tuse_rt_D = 3;
    expect_v("w_only_fwd_rt_E", S_FRTE, 2);
    expect_v("w_only_fwd_rs_E", S_FRSE, 0);
    step();
    clear_inputs();
    GRFWE_M = 1; GRFWE_W = 1;
    expect_v("r0_fwd_rs_E", S_FRSE, 0);
    expect_v("r0_fwd_rt_E", S_FRTE, 0);
    expect_v("r0_stall", S_STALL, 0);

    // store data forwarding from WB
    step();
    clear_inputs();
    rt_M = 4; WA_W = 4; GRFWE_W = 1;
    expect_v("st_fwd", S_FRTM, 1);
    step();
    GRFWE_W = 0;
    expect_v("st_nowe", S_FRTM, 0);

    // div with md_use_D held: 1 start cycle + 10 busy cycles stalled
    step();
    clear_inputs();
    md_start_E = 1; md_div_E = 1; md_use_D = 1;
    expect_v("div_start_stall", S_STALL, 1);
    expect_v("div_start_busy", S_BUSY, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      md_start_E = 0;
      expect_v("div_busy", S_BUSY, 1);
      expect_v("div_stall", S_STALL, 1);
    end
    step();
    expect_v("div_done_busy", S_BUSY, 0);
    expect_v("div_done_stall", S_STALL, 0);
    expect_v("div_cnt", S_CNT, 13);

    // mult without a consumer: 5 busy cycles, no stall
    step();
    md_use_D = 0; md_start_E = 1; md_div_E = 0;
    expect_v("mul_start_busy", S_BUSY, 0);
    expect_v("mul_start_stall", S_STALL, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      md_start_E = 0;
      expect_v("mul_busy", S_BUSY, 1);
    end
    step();
    expect_v("mul_done_busy", S_BUSY, 0);
    expect_v("mul_cnt", S_CNT, 13);

    // async reset three cycles into a div
    step();
    md_start_E = 1; md_div_E = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      md_start_E = 0; md_use_D = 1;
      expect_v("div2_busy", S_BUSY, 1);
    end
    step();
    reset = 1'b1;
    expect_v("arst_busy", S_BUSY, 0);
    expect_v("arst_cnt", S_CNT, 0);
    expect_v("arst_stall", S_STALL, 0);
    step();
    reset = 1'b0; md_use_D = 0;
    step();
    md_start_E = 1; md_div_E = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      md_start_E = 0;
      expect_v("mul2_busy", S_BUSY, 1);
    end
    step();
    expect_v("mul2_done", S_BUSY, 0);
    expect_v("mul2_cnt", S_CNT, 0);

    // 7 data-stall cycles from an EX producer
    for (int i = 0; i < 7; i++) begin
      step();
      WA_E = 5; GRFWE_E = 1; Tnew_E = 1; rt_D = 5; Tuse_rt_D = 0;
      expect_v("ds_stall", S_STALL, 1);
    end
    step();
    clear_inputs();
    expect_v("ds_cnt7", S_CNT, 7);
    expect_v("ds_clear_stall", S_STALL, 0);

    // wrap: preload all-ones, take one stall cycle
    step();
    WA_M = 6; GRFWE_M = 1; Tnew_M = 2; rs_D = 6; Tuse_rs_D = 1;
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #2;
    release dut.stall_cnt;
    step();
    clear_inputs();
    expect_v("wrap_cnt", S_CNT, 0);

    step();
    step();
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, 0 required", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
